input_conditioner: RTL and testbench

- Parametrised multi-channel input conditioner for board-level inputs such as buttons and switches, sitting between raw FPGA pins and the core logic.
- Per channel: synchronises the raw input, debounces it, and publishes a clean level plus one-cycle rise and fall pulses.
- Per channel: keeps a sticky pending-event flag that core logic acknowledges with a clear strobe.
- Successor to the single-input, 2-bit-output conditioner; adds channel count, configurable synchroniser depth, debounce filtering and event latching.

---
 rtl/input_conditioner.sv | 117 +++++++++++
 tb/tb_input_conditioner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per channel a synchroniser chain, a
// debounce filter that publishes a stable level with registered rise/fall
// pulses, and a sticky pending-event flag acknowledged by a clear strobe.

module input_conditioner_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inp,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic pend
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   pend_q, pend_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Shift the raw pin into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], inp};
  end

  // Debounce: count consecutive disagreement cycles; on reaching the
  // threshold adopt the new level and emit a one-cycle edge pulse.
  // The pending flag is set by an edge, which beats a same-cycle clear.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = sync;
      rise_d  = sync;
      fall_d  = ~sync;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (rise_d || fall_d) pend_d = 1'b1;
    else if (clr)         pend_d = 1'b0;
    else                  pend_d = pend_q;
  end

  // State registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign pend  = pend_q;
endmodule

module input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] inp,
  input  logic [CHANNELS-1:0] clr,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] pend,
  output logic                any_pend
);
  // One fully independent conditioner per channel.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    input_conditioner_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .inp  (inp[g]),
      .clr  (clr[g]),
      .level(level[g]),
      .rise (rise[g]),
      .fall (fall[g]),
      .pend (pend[g])
    );
  end

  assign any_pend = |pend;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench: a cycle table for reset, glitch and clean-edge behaviour,
// then hand-written sequences for set-beats-clear, mid-operation reset and
// a CHANNELS=1 / SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance.

module tb_input_conditioner;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] inp, clr, level, rise, fall, pend;
  logic       any_pend;
  logic       rst1, inp1, clr1, level1, rise1, fall1, pend1, any_pend1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_conditioner #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .inp(inp), .clr(clr), .level(level), .rise(rise),
    .fall(fall), .pend(pend), .any_pend(any_pend)
  );

  input_conditioner #(.CHANNELS(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .inp(inp1), .clr(clr1), .level(level1), .rise(rise1),
    .fall(fall1), .pend(pend1), .any_pend(any_pend1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] inp;
    logic [3:0] clr;
    logic [3:0] lvl;
    logic [3:0] ri;
    logic [3:0] fa;
    logic [3:0] pe;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [3:0] i, logic [3:0] c, logic [3:0] l,
                              logic [3:0] ri, logic [3:0] fa, logic [3:0] pe);
    vec_t v;
    v.rst = r; v.inp = i; v.clr = c; v.lvl = l; v.ri = ri; v.fa = fa; v.pe = pe;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag, logic [3:0] l, logic [3:0] ri,
                           logic [3:0] fa, logic [3:0] pe);
    check({tag, " level"}, level, l);
    check({tag, " rise"}, rise, ri);
    check({tag, " fall"}, fall, fa);
    check({tag, " pend"}, pend, pe);
    check({tag, " any_pend"}, {3'b0, any_pend}, {3'b0, |pe});
  endtask

  initial begin
    rst = 1'b1; inp = '0; clr = '0;
    rst1 = 1'b1; inp1 = 1'b0; clr1 = 1'b0;

    // Reset with all inputs high, rise on the 6th edge after release (k+5)
    add(1, 4'hF, 0, 0, 0, 0, 0);
    add(1, 4'hF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'hF, 0, 0, 0, 0, 0);
    add(0, 4'hF, 0, 4'hF, 4'hF, 0, 4'hF);
    // Drop all inputs, fall at k+5, then clear all pending flags
    for (int i = 0; i < 5; i++) add(0, 4'h0, 0, 4'hF, 0, 0, 4'hF);
    add(0, 4'h0, 0, 0, 0, 4'hF, 4'hF);
    add(0, 4'h0, 4'hF, 0, 0, 0, 0);
    add(0, 4'h0, 0, 0, 0, 0, 0);
    // Channel 0 glitches: 2 cycles then 3 cycles high, both rejected
    for (int i = 0; i < 2; i++) add(0, 4'h1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 4'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 4'h1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'h0, 0, 0, 0, 0, 0);
    // Channel 1 clean edge held 10 cycles, then clear
    for (int i = 0; i < 5; i++) add(0, 4'h2, 0, 0, 0, 0, 0);
    add(0, 4'h2, 0, 4'h2, 4'h2, 0, 4'h2);
    for (int i = 0; i < 4; i++) add(0, 4'h2, 0, 4'h2, 0, 0, 4'h2);
    add(0, 4'h2, 4'h2, 4'h2, 0, 0, 0);
    add(0, 4'h2, 0, 4'h2, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; inp = vecs[i].inp; clr = vecs[i].clr;
      step();
      check_all($sformatf("row%0d", i), vecs[i].lvl, vecs[i].ri, vecs[i].fa, vecs[i].pe);
    end
    clr = '0;

    // Set beats clear on channel 2
    inp = 4'h6;
    for (int i = 0; i < 6; i++) step();
    check("sbc rise2", {3'b0, rise[2]}, 4'h1);
    check("sbc level2", {3'b0, level[2]}, 4'h1);
    clr = 4'h4; inp = 4'h2;
    step();
    check("sbc clr pend2", {3'b0, pend[2]}, 4'h0);
    clr = 4'h0;
    for (int i = 0; i < 4; i++) step();
    check("sbc no early fall", {3'b0, fall[2]}, 4'h0);
    clr = 4'h4;
    step();
    check("sbc fall2", {3'b0, fall[2]}, 4'h1);
    check("sbc pend2 set wins", {3'b0, pend[2]}, 4'h1);
    clr = 4'h0;
    step();
    check("sbc pend2 held", {3'b0, pend[2]}, 4'h1);
    check("sbc fall2 one cycle", {3'b0, fall[2]}, 4'h0);

    // Mid-operation reset with channel 3 counter at 2
    inp = 4'hA;
    for (int i = 0; i < 4; i++) step();
    check("mid pre level3", {3'b0, level[3]}, 4'h0);
    rst = 1'b1;
    step();
    check_all("mid rst", 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all($sformatf("mid rel%0d", i), 0, 0, 0, 0);
    end
    step();
    check_all("mid rel rise", 4'hA, 4'hA, 0, 4'hA);

    // Parameter sweep instance: rise at k+3, 1-cycle glitch propagates
    step();
    rst1 = 1'b0; inp1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("p1 wait%0d level", i), {3'b0, level1}, 4'h0);
    end
    step();
    check("p1 rise", {3'b0, rise1}, 4'h1);
    check("p1 level", {3'b0, level1}, 4'h1);
    check("p1 pend", {3'b0, pend1}, 4'h1);
    check("p1 any_pend", {3'b0, any_pend1}, 4'h1);
    step();
    check("p1 rise one cycle", {3'b0, rise1}, 4'h0);
    inp1 = 1'b0;
    step();
    inp1 = 1'b1;
    step();
    step();
    check("p1 glitch pre", {3'b0, level1}, 4'h1);
    step();
    check("p1 glitch fall", {3'b0, fall1}, 4'h1);
    check("p1 glitch level0", {3'b0, level1}, 4'h0);
    step();
    check("p1 glitch rise", {3'b0, rise1}, 4'h1);
    check("p1 glitch fall gone", {3'b0, fall1}, 4'h0);
    check("p1 glitch level1", {3'b0, level1}, 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
